// File: rtl/video_timing_gen.sv
// video_timing_gen: free-running raster timing generator with a registered
// DE/VSYNC_n/HSYNC_n bundle, blanking flags, a selectable RGB888 test
// pattern and a completed-frame counter. Every output is registered and
// describes the counter position held during the previous enabled cycle.
module video_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 29,
  parameter int BAR_W    = 100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cen_i,
  input  logic [1:0]  pat_sel_i,
  input  logic [23:0] solid_rgb_i,
  output logic [2:0]  dvh_sync_o,
  output logic [1:0]  vh_blank_o,
  output logic [23:0] vid_rgb_o,
  output logic [15:0] frame_cnt_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The grey ramp reads h[9:2] and the checkerboard reads v[5], so the
  // counters never shrink below those bit positions.
  localparam int HW = ($clog2(H_TOTAL) < 10) ? 10 : $clog2(H_TOTAL);
  localparam int VW = ($clog2(V_TOTAL) < 6) ? 6 : $clog2(V_TOTAL);
  localparam int BW = $clog2(BAR_W + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG_C = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END_C = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG_C = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END_C = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [BW-1:0] bar_px_q, bar_px_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [1:0]    pat_q, pat_d;
  logic [23:0]   solid_q, solid_d;
  logic [2:0]    dvh_q, dvh_d;
  logic [1:0]    blank_q, blank_d;
  logic [23:0]   rgb_q, rgb_d;
  logic [15:0]   frame_q, frame_d;

  logic h_wrap, v_wrap, at_origin, de;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  // Next counter state, pattern latch and the decode of the current position.
  always_comb begin
    h_wrap    = (h_cnt_q == H_LAST);
    v_wrap    = (v_cnt_q == V_LAST);
    at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);

    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
    end

    // Bar position tracks h_cnt with a BAR_W-pixel sub-counter instead of a
    // divide; the index sticks at the last bar once the bars run out.
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (h_wrap) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (bar_px_q == BAR_LAST) begin
      bar_px_d  = '0;
      bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
    end else begin
      bar_px_d = bar_px_q + 1'b1;
    end

    // The pattern sampled at the origin already applies to the origin pixel.
    pat_d   = at_origin ? pat_sel_i : pat_q;
    solid_d = at_origin ? solid_rgb_i : solid_q;

    de      = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    dvh_d   = {de,
               ~((v_cnt_q >= VS_BEG_C) && (v_cnt_q < VS_END_C)),
               ~((h_cnt_q >= HS_BEG_C) && (h_cnt_q < HS_END_C))};
    blank_d = {(v_cnt_q >= V_ACT_C), (h_cnt_q >= H_ACT_C)};

    rgb_d = '0;
    if (de) begin
      case (pat_d)
        2'd0:    rgb_d = bar_colour(bar_idx_q);
        2'd1:    rgb_d = solid_d;
        2'd2:    rgb_d = {3{h_cnt_q[9:2]}};
        default: rgb_d = (h_cnt_q[5] ^ v_cnt_q[5]) ? 24'hFFFFFF : 24'h000000;
      endcase
    end

    frame_d = (h_wrap && v_wrap) ? frame_q + 16'd1 : frame_q;
  end

  // All state advances together on enabled cycles and clears asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
      pat_q     <= '0;
      solid_q   <= '0;
      dvh_q     <= 3'b011;
      blank_q   <= 2'b11;
      rgb_q     <= '0;
      frame_q   <= '0;
    end else if (cen_i) begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      pat_q     <= pat_d;
      solid_q   <= solid_d;
      dvh_q     <= dvh_d;
      blank_q   <= blank_d;
      rgb_q     <= rgb_d;
      frame_q   <= frame_d;
    end
  end

  assign dvh_sync_o  = dvh_q;
  assign vh_blank_o  = blank_q;
  assign vid_rgb_o   = rgb_q;
  assign frame_cnt_o = frame_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: reduced-size raster (112 x 79) so several frames fit
// in a short run. The reference model tracks only the number of enabled
// edges since reset and derives position, decode and pattern arithmetically.
module tb_video_timing_gen;

  localparam int HA = 96, HF = 4, HS = 6, HB = 6;
  localparam int VA = 70, VF = 3, VS = 2, VB = 4;
  localparam int BARW = 10;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cen_i;
  logic [1:0]  pat_sel_i;
  logic [23:0] solid_rgb_i;
  logic [2:0]  dvh_sync_o;
  logic [1:0]  vh_blank_o;
  logic [23:0] vid_rgb_o;
  logic [15:0] frame_cnt_o;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BAR_W(BARW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cen_i(cen_i),
    .pat_sel_i(pat_sel_i), .solid_rgb_i(solid_rgb_i),
    .dvh_sync_o(dvh_sync_o), .vh_blank_o(vh_blank_o),
    .vid_rgb_o(vid_rgb_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  bit mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] f_dvh(input int p);
    int h, v;
    h = p % HT;
    v = p / HT;
    f_dvh = {(h < HA && v < VA),
             !(v >= VA + VF && v < VA + VF + VS),
             !(h >= HA + HF && h < HA + HF + HS)};
  endfunction

  function automatic logic [1:0] f_blank(input int p);
    f_blank = {((p / HT) >= VA), ((p % HT) >= HA)};
  endfunction

  function automatic logic [23:0] f_rgb(input int p, input logic [1:0] pat, input logic [23:0] sol);
    int h, v, b;
    logic [7:0] g;
    h = p % HT;
    v = p / HT;
    if (!(h < HA && v < VA)) return 24'h0;
    case (pat)
      2'd0: begin
        b = h / BARW;
        if (b > 7) b = 7;
        return BARS[b];
      end
      2'd1: return sol;
      2'd2: begin
        g = 8'((h >> 2) & 255);
        return {g, g, g};
      end
      default: return ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  int          cnt;
  logic [1:0]  lat_pat;
  logic [23:0] lat_sol;
  logic [2:0]  m_dvh;
  logic [1:0]  m_blank;
  logic [23:0] m_rgb;
  logic [15:0] m_frame;
  bit          stepped;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt     <= 0;
      lat_pat <= 2'd0;
      lat_sol <= 24'h0;
      m_dvh   <= 3'b011;
      m_blank <= 2'b11;
      m_rgb   <= 24'h0;
      m_frame <= 16'h0;
      stepped <= 1'b0;
    end else begin
      stepped <= cen_i;
      if (cen_i) begin
        cnt     <= cnt + 1;
        if (cnt % FT == 0) begin
          lat_pat <= pat_sel_i;
          lat_sol <= solid_rgb_i;
        end
        m_dvh   <= f_dvh(cnt % FT);
        m_blank <= f_blank(cnt % FT);
        m_rgb   <= f_rgb(cnt % FT, (cnt % FT == 0) ? pat_sel_i : lat_pat,
                         (cnt % FT == 0) ? solid_rgb_i : lat_sol);
        m_frame <= 16'(((cnt + 1) / FT) % 65536);
      end
    end
  end

  // ---------------- compare and timing monitor ----------------
  initial begin
    int de_run, hs_run, vs_run, vb_run, since;
    bit have_fall, prev_vs;
    de_run = 0; hs_run = 0; vs_run = 0; vb_run = 0; since = 0;
    have_fall = 1'b0; prev_vs = 1'b1;
    wait (mon_on);
    forever begin
      @(negedge clk_i);
      check("dvh_sync", dvh_sync_o, m_dvh);
      check("vh_blank", vh_blank_o, m_blank);
      check("vid_rgb", vid_rgb_o, m_rgb);
      check("frame_cnt", frame_cnt_o, m_frame);
      if (rst_i) begin
        de_run = 0; hs_run = 0; vs_run = 0; vb_run = 0; since = 0;
        have_fall = 1'b0; prev_vs = 1'b1;
      end else if (stepped) begin
        if (dvh_sync_o[2]) de_run++;
        else if (de_run != 0) begin check("de_run_len", de_run, HA); de_run = 0; end
        if (!dvh_sync_o[0]) hs_run++;
        else if (hs_run != 0) begin check("hsync_low_len", hs_run, HS); hs_run = 0; end
        if (!dvh_sync_o[1]) vs_run++;
        else if (vs_run != 0) begin check("vsync_low_len", vs_run, VS * HT); vs_run = 0; end
        if (vh_blank_o[1]) vb_run++;
        else if (vb_run != 0) begin check("vblank_len", vb_run, (VT - VA) * HT); vb_run = 0; end
        since++;
        if (prev_vs && !dvh_sync_o[1]) begin
          if (have_fall) check("vsync_period", since, FT);
          have_fall = 1'b1;
          since = 0;
        end
        prev_vs = dvh_sync_o[1];
      end
    end
  end

  // Advance with cen high until the outputs show position (h, v).
  task automatic run_to(input int h, input int v);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      @(negedge clk_i);
      if (stepped && cnt > 0 && ((cnt - 1) % FT) == v * HT + h) found = 1'b1;
    end
    if (!found) check("run_to_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b1; cen_i = 1'b0; pat_sel_i = 2'd0; solid_rgb_i = 24'h0;
    repeat (3) @(negedge clk_i);
    mon_on = 1'b1;
    check("rst_dvh", dvh_sync_o, 3'b011);
    check("rst_blank", vh_blank_o, 2'b11);
    check("rst_rgb", vid_rgb_o, 24'h0);
    check("rst_frame", frame_cnt_o, 16'h0);

    @(negedge clk_i);
    rst_i = 1'b0; cen_i = 1'b1;
    @(negedge clk_i);
    check("first_dvh", dvh_sync_o, 3'b111);
    check("first_blank", vh_blank_o, 2'b00);
    check("first_rgb", vid_rgb_o, 24'hFFFFFF);
    check("first_frame", frame_cnt_o, 16'h0);

    run_to(9, 0);  check("bar_h9", vid_rgb_o, 24'hFFFFFF);
    run_to(10, 0); check("bar_h10", vid_rgb_o, 24'hFFFF00);
    run_to(65, 0); check("bar_h65", vid_rgb_o, 24'h0000FF);
    run_to(75, 0); check("bar_h75", vid_rgb_o, 24'h000000);
    run_to(85, 0); check("bar_sat_h85", vid_rgb_o, 24'h000000);
    run_to(HA, 0);
    check("end_de", dvh_sync_o[2], 1'b0);
    check("end_rgb", vid_rgb_o, 24'h0);
    check("end_blank", vh_blank_o, 2'b01);

    // Freeze mid-line, then resume.
    run_to(40, 1);
    cen_i = 1'b0;
    repeat (50) @(negedge clk_i);
    check("frozen_rgb", vid_rgb_o, 24'hFF00FF);
    check("frozen_dvh", dvh_sync_o, 3'b111);
    cen_i = 1'b1;
    run_to(50, 1); check("resume_rgb", vid_rgb_o, 24'hFF0000);

    // Mid-frame pattern change waits for the next frame.
    run_to(0, 10);
    pat_sel_i = 2'd3;
    run_to(40, 20); check("still_bars", vid_rgb_o, 24'hFF00FF);
    run_to(0, 0);
    check("chk_0_0", vid_rgb_o, 24'h000000);
    check("frame_one", frame_cnt_o, 16'd1);
    run_to(32, 0);  check("chk_32_0", vid_rgb_o, 24'hFFFFFF);
    run_to(32, 32); check("chk_32_32", vid_rgb_o, 24'h000000);

    // Randomized enable and pattern traffic.
    for (int i = 0; i < 35000; i++) begin
      @(negedge clk_i);
      cen_i = ($urandom % 8) != 0;
      if ($urandom % 300 == 0) begin
        pat_sel_i   = 2'($urandom);
        solid_rgb_i = 24'($urandom);
      end
    end

    // Asynchronous reset between edges.
    cen_i = 1'b1;
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("async_dvh", dvh_sync_o, 3'b011);
    check("async_blank", vh_blank_o, 2'b11);
    check("async_rgb", vid_rgb_o, 24'h0);
    check("async_frame", frame_cnt_o, 16'h0);
    pat_sel_i = 2'd2;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("restart_dvh", dvh_sync_o, 3'b111);
    check("restart_grey0", vid_rgb_o, 24'h000000);
    check("restart_frame", frame_cnt_o, 16'h0);
    run_to(20, 0); check("grey_h20", vid_rgb_o, 24'h050505);

    pat_sel_i = 2'd1; solid_rgb_i = 24'h123456;
    run_to(5, 3);  check("grey_h5_v3", vid_rgb_o, 24'h010101);
    run_to(5, 3);  check("solid_h5_v3", vid_rgb_o, 24'h123456);
    check("frame_after_restart", frame_cnt_o, 16'd1);

    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_i);
      cen_i = ($urandom % 4) != 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
